// File: rtl/timer_pkg.sv
// Shared command and state encodings for the interval-timer controller.
package timer_pkg;

   typedef enum logic [1:0] {
      OP_START  = 2'd0,
      OP_STOP   = 2'd1,
      OP_PAUSE  = 2'd2,
      OP_RESUME = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/timer_sequencer_if.sv
// Command channel of the timer: valid/ready handshake plus the error response.
interface timer_sequencer_if #(
   parameter int WIDTH          = 4,
   parameter int PRESCALE_WIDTH = 4
) ();
   import timer_pkg::*;

   logic                      cmd_valid;
   logic                      cmd_ready;
   op_t                       cmd_op;
   logic [WIDTH-1:0]          cmd_period;
   logic [PRESCALE_WIDTH-1:0] cmd_prescale;
   logic                      cmd_periodic;
   logic                      cmd_error;

   modport master (
      output cmd_valid, cmd_op, cmd_period, cmd_prescale, cmd_periodic,
      input  cmd_ready, cmd_error
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_period, cmd_prescale, cmd_periodic,
      output cmd_ready, cmd_error
   );

endinterface

// File: rtl/timer_prescaler.sv
// Divide-by-(divisor+1) enable generator; tick is combinational so the
// sequencer sees it in the same cycle the count reaches the divisor.
module timer_prescaler #(
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] divisor,
   output logic                      tick
);

   localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

   logic [PRESCALE_WIDTH-1:0] r_count;

   assign tick = enable && (r_count == divisor);

   // Clear has priority so a restart always begins a fresh division interval.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= tick ? '0 : (r_count + ONE);
      end
   end

endmodule

// File: rtl/timer_sequencer.sv
// Interval-timer controller: command FSM, period compare and count register,
// driven by a prescaled tick from timer_prescaler.
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   timer_sequencer_if.slave bus,
   output logic [WIDTH-1:0] value,
   output logic [1:0]       state,
   output logic             expire
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t                    r_state;
   logic [WIDTH-1:0]          r_value;
   logic [WIDTH-1:0]          r_period;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic                      r_periodic;
   logic                      r_expire;
   logic                      r_error;
   logic                      r_ready;

   logic w_accept;
   logic w_start;
   logic w_count_en;
   logic w_tick;

   // Any accepted command pre-empts counting in that cycle, so a colliding tick is lost.
   assign w_accept   = bus.cmd_valid && r_ready;
   assign w_start    = w_accept && (bus.cmd_op == OP_START);
   assign w_count_en = (r_state == ST_RUN) && !w_accept;

   timer_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .clear  (w_start),
      .enable (w_count_en),
      .divisor(r_prescale),
      .tick   (w_tick)
   );

   // Command handling, tick-driven counting and the registered pulse outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_value    <= '0;
         r_period   <= '0;
         r_prescale <= '0;
         r_periodic <= 1'b0;
         r_expire   <= 1'b0;
         r_error    <= 1'b0;
         r_ready    <= 1'b0;
      end else begin
         r_ready  <= 1'b1;
         r_expire <= 1'b0;
         r_error  <= 1'b0;
         if (w_accept) begin
            case (bus.cmd_op)
               OP_START: begin
                  r_value    <= '0;
                  r_period   <= bus.cmd_period;
                  r_prescale <= bus.cmd_prescale;
                  r_periodic <= bus.cmd_periodic;
                  r_state    <= ST_RUN;
               end
               OP_STOP: begin
                  if (r_state == ST_IDLE) r_error <= 1'b1;
                  else                    r_state <= ST_IDLE;
               end
               OP_PAUSE: begin
                  if (r_state == ST_RUN) r_state <= ST_PAUSE;
                  else                   r_error <= 1'b1;
               end
               OP_RESUME: begin
                  if (r_state == ST_PAUSE) r_state <= ST_RUN;
                  else                     r_error <= 1'b1;
               end
            endcase
         end else if (w_tick) begin
            if (r_value == r_period) begin
               r_expire <= 1'b1;
               if (r_periodic) r_value <= '0;
               else            r_state <= ST_DONE;
            end else begin
               r_value <= r_value + ONE;
            end
         end
      end
   end

   assign value         = r_value;
   assign state         = r_state;
   assign expire        = r_expire;
   assign bus.cmd_ready = r_ready;
   assign bus.cmd_error = r_error;

endmodule
